ext_pipe_unit: RTL and testbench

- Parametrised, registered immediate-extension stage for the pipelined CPU datapath.
- Accepts an immediate, an extension mode and a tag (destination register index) through a valid/ready handshake.
- Produces the extended word one cycle later through a 2-entry skid buffer, so back-pressure from the consumer never creates a combinational ready path.
- Supports a synchronous flush for branch/exception squash.

---
 rtl/ext_pkg.sv | 9 +
 rtl/ext_core.sv | 24 ++
 rtl/ext_pipe_unit.sv | 68 ++++++
 tb/tb_ext_pipe_unit.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/ext_pkg.sv
// ext_pkg: extension-mode encodings shared by the immediate extender and its pipeline stage
package ext_pkg;
  localparam int EXT_OP_W = 3;
  localparam logic [EXT_OP_W-1:0] EXT_ZERO      = 3'd0;
  localparam logic [EXT_OP_W-1:0] EXT_SIGN      = 3'd1;
  localparam logic [EXT_OP_W-1:0] EXT_UPPER     = 3'd2;
  localparam logic [EXT_OP_W-1:0] EXT_SIGN_SHL2 = 3'd3;
  localparam logic [EXT_OP_W-1:0] EXT_SHAMT     = 3'd4;
endpackage

// File: rtl/ext_core.sv
// ext_core: combinational immediate extender; ops above SHAMT are illegal and yield all ones
module ext_core
  import ext_pkg::*;
#(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32
) (
  input  logic [IMM_W-1:0]    imm,
  input  logic [EXT_OP_W-1:0] op,
  output logic [DATA_W-1:0]   data,
  output logic                err
);
  logic [DATA_W-1:0] sx;
  always_comb begin
    sx = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    err = op > EXT_SHAMT;
    data = op == EXT_ZERO      ? {{(DATA_W-IMM_W){1'b0}}, imm} :
           op == EXT_SIGN      ? sx :
           op == EXT_UPPER     ? {imm, {(DATA_W-IMM_W){1'b0}}} :
           op == EXT_SIGN_SHL2 ? sx << 2 :
           op == EXT_SHAMT     ? {{(DATA_W-5){1'b0}}, imm[4:0]} :
                                 {DATA_W{1'b1}};
  end
endmodule

// File: rtl/ext_pipe_unit.sv
// ext_pipe_unit: registered immediate-extension stage behind a 2-entry skid buffer with flush
module ext_pipe_unit
  import ext_pkg::*;
#(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IMM_W-1:0]    in_imm,
  input  logic [EXT_OP_W-1:0] in_op,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [TAG_W-1:0]    out_tag,
  output logic                out_err
);
  logic [DATA_W-1:0] ext_data, skid_data;
  logic [TAG_W-1:0]  skid_tag;
  logic              ext_err, skid_err, skid_valid, acc, cons;
  ext_core #(.IMM_W(IMM_W), .DATA_W(DATA_W)) u_core (
    .imm  (in_imm),
    .op   (in_op),
    .data (ext_data),
    .err  (ext_err)
  );
  // in_ready is just the inverted skid flop, so out_ready never reaches it combinationally
  assign in_ready = !skid_valid;
  assign acc      = in_valid && in_ready;
  assign cons     = out_valid && out_ready;
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_tag    <= '0;
      out_err    <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_tag   <= '0;
      skid_err   <= 1'b0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (cons && skid_valid) begin
      out_data   <= skid_data;
      out_tag    <= skid_tag;
      out_err    <= skid_err;
      skid_valid <= 1'b0;
    end else if (acc && (!out_valid || cons)) begin
      out_valid <= 1'b1;
      out_data  <= ext_data;
      out_tag   <= in_tag;
      out_err   <= ext_err;
    end else if (acc) begin
      skid_valid <= 1'b1;
      skid_data  <= ext_data;
      skid_tag   <= in_tag;
      skid_err   <= ext_err;
    end else if (cons) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ext_pipe_unit.sv
// tb_ext_pipe_unit: scoreboard bench for the immediate-extension stage
module tb_ext_pipe_unit;
  import ext_pkg::*;
  typedef struct packed {logic [31:0] d; logic [4:0] t; logic e;} ent_t;
  logic clk = 1'b0, reset, flush, in_valid, out_ready, in_ready, out_valid, out_err;
  logic [15:0] in_imm;
  logic [2:0]  in_op;
  logic [4:0]  in_tag, out_tag;
  logic [31:0] out_data, exp_data;
  logic        exp_err;
  logic        in2_valid, in2_ready, out2_valid, out2_err;
  logic [11:0] in2_imm;
  logic [2:0]  in2_op;
  logic [4:0]  out2_tag;
  logic [15:0] out2_data;
  ent_t q[$];
  ent_t e;
  int pass_cnt = 0, total = 0;
  always #5 clk = ~clk;
  ext_pipe_unit dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_imm(in_imm), .in_op(in_op), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .out_err(out_err)
  );
  ext_pipe_unit #(.IMM_W(12), .DATA_W(16), .TAG_W(5)) dut2 (
    .clk(clk), .reset(reset), .flush(1'b0), .in_valid(in2_valid), .in_ready(in2_ready),
    .in_imm(in2_imm), .in_op(in2_op), .in_tag(5'd0), .out_valid(out2_valid), .out_ready(1'b1),
    .out_data(out2_data), .out_tag(out2_tag), .out_err(out2_err)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [15:0] imm, input logic [2:0] op,
                       input logic [4:0] tag, input logic [31:0] d, input logic er);
    in_valid = v; in_imm = imm; in_op = op; in_tag = tag; exp_data = d; exp_err = er;
  endtask
  // Monitor: compares each consumed output, then records what the coming edge will accept
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (q.size() == 0) check("unexpected_out", {27'd0, out_tag}, 32'hxxxxxxxx);
      else begin
        e = q.pop_front();
        check("out_data", out_data, e.d);
        check("out_tag", {27'd0, out_tag}, {27'd0, e.t});
        check("out_err", {31'd0, out_err}, {31'd0, e.e});
      end
    end
    if (reset || flush) q.delete();
    else if (in_valid && in_ready) q.push_back(ent_t'({exp_data, in_tag, exp_err}));
  end
  logic [2:0]  vop[6];
  logic [31:0] vd[6];
  logic [2:0]  sop[3];
  logic [15:0] sd[3];
  initial begin
    vop = '{EXT_ZERO, EXT_SIGN, EXT_UPPER, EXT_SIGN_SHL2, EXT_SHAMT, 3'd7};
    vd  = '{32'h00008001, 32'hFFFF8001, 32'h80010000, 32'hFFFE0004, 32'h00000001, 32'hFFFFFFFF};
    sop = '{EXT_SIGN, EXT_UPPER, EXT_SIGN_SHL2};
    sd  = '{16'hF800, 16'h8000, 16'hE000};
    reset = 1; flush = 0; out_ready = 1; in2_valid = 0; in2_imm = '0; in2_op = '0;
    drive(0, '0, '0, '0, '0, 0);
    step(); step();
    reset = 0;
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_in_ready", {31'd0, in_ready}, 1);
    check("rst_out_data", out_data, 0);
    check("rst_out_tag", {27'd0, out_tag}, 0);
    check("rst_out_err", {31'd0, out_err}, 0);
    for (int i = 0; i < 6; i++) begin
      drive(1, 16'h8001, vop[i], 5'(i), vd[i], i == 5);
      step();
      drive(0, '0, '0, '0, '0, 0);
      check("latency_valid", {31'd0, out_valid}, 1);
      step();
      check("single_drained", {31'd0, out_valid}, 0);
    end
    out_ready = 0;
    drive(1, 16'h0005, EXT_ZERO, 5'd1, 32'h5, 0);
    step();
    drive(1, 16'h0003, EXT_SIGN, 5'd2, 32'h3, 0);
    step();
    drive(0, '0, '0, '0, '0, 0);
    check("bp_in_ready_full", {31'd0, in_ready}, 0);
    check("bp_head_tag", {27'd0, out_tag}, 1);
    step();
    check("bp_stall_tag", {27'd0, out_tag}, 1);
    check("bp_stall_data", out_data, 32'h5);
    out_ready = 1;
    step();
    check("bp_in_ready_back", {31'd0, in_ready}, 1);
    check("bp_next_tag", {27'd0, out_tag}, 2);
    step();
    check("bp_drained", {31'd0, out_valid}, 0);
    for (int i = 0; i < 10; i++) begin
      drive(1, 16'(i * 3), EXT_ZERO, 5'(i), 32'(i * 3), 0);
      step();
      check("stream_in_ready", {31'd0, in_ready}, 1);
      check("stream_tag", {27'd0, out_tag}, 32'(i));
    end
    drive(0, '0, '0, '0, '0, 0);
    step();
    check("stream_drained", {31'd0, out_valid}, 0);
    out_ready = 0;
    drive(1, 16'h0011, EXT_ZERO, 5'd3, 32'h11, 0);
    step();
    drive(1, 16'h0012, EXT_ZERO, 5'd4, 32'h12, 0);
    step();
    drive(1, 16'h0013, EXT_ZERO, 5'd5, 32'h13, 0);
    flush = 1;
    step();
    flush = 0;
    drive(0, '0, '0, '0, '0, 0);
    check("flush_out_valid", {31'd0, out_valid}, 0);
    check("flush_in_ready", {31'd0, in_ready}, 1);
    out_ready = 1;
    drive(1, 16'h0014, EXT_ZERO, 5'd6, 32'h14, 0);
    flush = 1;
    step();
    flush = 0;
    drive(0, '0, '0, '0, '0, 0);
    check("flush_accept_dropped", {31'd0, out_valid}, 0);
    step(); step();
    out_ready = 0;
    drive(1, 16'hFFFF, EXT_SIGN, 5'd7, 32'hFFFFFFFF, 0);
    step();
    drive(1, 16'h0001, 3'd7, 5'd8, 32'hFFFFFFFF, 1);
    step();
    drive(0, '0, '0, '0, '0, 0);
    reset = 1; flush = 1;
    step();
    reset = 0; flush = 0;
    check("mid_rst_out_valid", {31'd0, out_valid}, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_out_tag", {27'd0, out_tag}, 0);
    check("mid_rst_out_err", {31'd0, out_err}, 0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 1);
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      in2_valid = 1; in2_imm = 12'h800; in2_op = sop[i];
      step();
      in2_valid = 0;
      check("sweep_valid", {31'd0, out2_valid}, 1);
      check("sweep_data", {16'd0, out2_data}, {16'd0, sd[i]});
      step();
    end
    step();
    check("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
